// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NCH valid/ready demux, one output word register per channel, 1-cycle latency.
// in_ready tracks the addressed slot (all slots when broadcasting); define DEMUX_BCAST_EN to enable broadcast.
module demux_stream #(
  parameter int W   = 8,
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             bcast,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [NCH*W-1:0] out_data,
  output logic             err
);
  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  logic [NCH-1:0]        r_valid;
  logic [NCH-1:0][W-1:0] r_data;
  logic                  r_err;
  logic [NCH-1:0]        w_free;
  logic                  w_free_sel;
  logic                  w_sel_ok;
  logic                  w_bcast;
  logic                  w_accept;
  logic [NCH-1:0]        w_load;

`ifdef DEMUX_BCAST_EN
  assign w_bcast = bcast;
`else
  logic w_unused_bcast;
  assign w_unused_bcast = bcast;
  assign w_bcast        = 1'b0;
`endif

  // A slot being drained this cycle can take a new word on the same edge.
  assign w_free   = ~r_valid | out_ready;
  assign w_sel_ok = ({1'b0, in_sel} < NCH_L);

  always_comb begin
    w_free_sel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_sel == SELW'(i)) begin
        w_free_sel = w_free[i];
      end
    end
  end

  // Out-of-range selects are always accepted so a bad word never wedges the producer.
  assign in_ready = enable & (w_bcast ? (&w_free) : (w_sel_ok ? w_free_sel : 1'b1));
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < NCH; i++) begin
      w_load[i] = w_accept & (w_bcast | (in_sel == SELW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_bcast & ~w_sel_ok;
      for (int i = 0; i < NCH; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= in_data;
        end else if (out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign err       = r_err;
endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: scoreboard per channel plus scenario tasks; second instance with NCH=3 for bad selects.
module tb_demux_stream;
  localparam int W   = 8;
  localparam int NCH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            in_valid = 1'b0;
  logic            bcast = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic [1:0]      in_sel = 2'd0;
  logic [3:0]      out_ready = 4'b0000;
  logic            in_ready;
  logic [3:0]      out_valid;
  logic [31:0]     out_data;
  logic            err;

  logic            in_valid3 = 1'b0;
  logic [1:0]      in_sel3 = 2'd0;
  logic [2:0]      out_ready3 = 3'b000;
  logic            in_ready3;
  logic [2:0]      out_valid3;
  logic [23:0]     out_data3;
  logic            err3;

  int              total = 0;
  int              bad = 0;
  logic [7:0]      sb [NCH][$];
  logic [7:0]      sb_exp;

  demux_stream #(.W(W), .NCH(NCH)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .bcast(bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err)
  );

  demux_stream #(.W(W), .NCH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
    .in_sel(in_sel3), .bcast(1'b0),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .err(err3)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop on every output transfer, push on every input transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          total++;
          if (sb[i].size() == 0) begin
            bad++;
            $display("FAIL sb_underflow ch%0d got=%02h expected=none", i, out_data[i*8 +: 8]);
          end else begin
            sb_exp = sb[i].pop_front();
            if (out_data[i*8 +: 8] !== sb_exp) begin
              bad++;
              $display("FAIL sb_data ch%0d got=%02h expected=%02h", i, out_data[i*8 +: 8], sb_exp);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
`ifdef DEMUX_BCAST_EN
        if (bcast) begin
          for (int i = 0; i < NCH; i++) sb[i].push_back(in_data);
        end else begin
          sb[in_sel].push_back(in_data);
        end
`else
        sb[in_sel].push_back(in_data);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_out_valid got=%b expected=0000", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h expected=00000000", out_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b expected=0", err); end
    total++; if (out_valid3 !== 3'b000 || err3 !== 1'b0) begin bad++; $display("FAIL rst_dut3 got=%b/%b expected=000/0", out_valid3, err3); end
    tick();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_nothing_delivered got=%b expected=0000", out_valid); end
  endtask

  task automatic test_unicast();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready_empty got=%b expected=1", in_ready); end
    tick();
    in_data = 8'h77;
    #1;
    total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL uni_out_valid got=%b expected=0010", out_valid); end
    total++; if (out_data[15:8] !== 8'h3C) begin bad++; $display("FAIL uni_out_data got=%h expected=3c", out_data[15:8]); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL uni_full_ready got=%b expected=0", in_ready); end
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL uni_hold_ready got=%b expected=0", in_ready); end
    out_ready = 4'b0010;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_drain_ready got=%b expected=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL uni_reload_valid got=%b expected=0010", out_valid); end
    total++; if (out_data[15:8] !== 8'h77) begin bad++; $display("FAIL uni_reload_data got=%h expected=77", out_data[15:8]); end
    tick();
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL uni_drained got=%b expected=0000", out_valid); end
    total++; if (out_data[15:8] !== 8'h77) begin bad++; $display("FAIL uni_stale_data got=%h expected=77", out_data[15:8]); end
    out_ready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b0001;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        total++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'(k - 1)) begin
          bad++; $display("FAIL b2b_deliver k=%0d got=%b/%h expected=1/%h", k, out_valid[0], out_data[7:0], 8'(k - 1));
        end
      end
      if (k < 8) begin
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(k);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b expected=1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b expected=0", out_valid[0]); end
    out_ready = 4'b0000;
  endtask

  task automatic test_isolation_enable();
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hC3;
    tick();
    out_ready = 4'b0001; in_sel = 2'd0; in_data = 8'hD0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL iso_ready_d0 got=%b expected=1", in_ready); end
    tick();
    in_data = 8'hD1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL iso_ready_d1 got=%b expected=1", in_ready); end
    total++; if (out_valid !== 4'b1001) begin bad++; $display("FAIL iso_valid got=%b expected=1001", out_valid); end
    tick();
    enable = 1'b0; in_data = 8'hE0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL en_off_ready got=%b expected=0", in_ready); end
    total++; if (out_valid !== 4'b1001 || out_data[7:0] !== 8'hD1) begin bad++; $display("FAIL en_off_hold got=%b/%h expected=1001/d1", out_valid, out_data[7:0]); end
    tick();
    total++; if (out_valid !== 4'b1000) begin bad++; $display("FAIL en_off_drain got=%b expected=1000", out_valid); end
    enable = 1'b1; in_sel = 2'd3;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL iso_ch3_stalled got=%b expected=0", in_ready); end
    total++; if (out_data[31:24] !== 8'hC3) begin bad++; $display("FAIL iso_ch3_data got=%h expected=c3", out_data[31:24]); end
    in_valid = 1'b0; out_ready = 4'b1000;
    tick();
    out_ready = 4'b0000;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL iso_final got=%b expected=0000", out_valid); end
  endtask

  task automatic test_invalid_sel();
    out_ready3 = 3'b000; in_valid3 = 1'b1; in_sel3 = 2'd1; in_data = 8'h11;
    tick();
    in_sel3 = 2'd3; in_data = 8'h99;
    #1;
    total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL inv_ready got=%b expected=1", in_ready3); end
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL inv_err_before got=%b expected=0", err3); end
    tick();
    total++; if (err3 !== 1'b1) begin bad++; $display("FAIL inv_err_pulse got=%b expected=1", err3); end
    total++; if (out_valid3 !== 3'b010) begin bad++; $display("FAIL inv_valid got=%b expected=010", out_valid3); end
    tick();
    total++; if (err3 !== 1'b1) begin bad++; $display("FAIL inv_err_consec got=%b expected=1", err3); end
    in_valid3 = 1'b0;
    tick();
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL inv_err_clear got=%b expected=0", err3); end
    total++; if (out_valid3 !== 3'b010 || out_data3[15:8] !== 8'h11) begin bad++; $display("FAIL inv_untouched got=%b/%h expected=010/11", out_valid3, out_data3[15:8]); end
    out_ready3 = 3'b010;
    tick();
    out_ready3 = 3'b000;
    total++; if (out_valid3 !== 3'b000) begin bad++; $display("FAIL inv_drain got=%b expected=000", out_valid3); end
  endtask

  task automatic test_bcast();
`ifdef DEMUX_BCAST_EN
    out_ready = 4'b0000; in_valid = 1'b1; bcast = 1'b0; in_sel = 2'd2; in_data = 8'h22;
    tick();
    bcast = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_blocked got=%b expected=0", in_ready); end
    tick();
    total++; if (in_ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL bc_hold got=%b/%b expected=0/0", in_ready, err); end
    out_ready = 4'b0100;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_release got=%b expected=1", in_ready); end
    tick();
    in_valid = 1'b0; bcast = 1'b0; out_ready = 4'b0000;
    #1;
    total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL bc_valid got=%b expected=1111", out_valid); end
    for (int i = 0; i < NCH; i++) begin
      total++; if (out_data[i*8 +: 8] !== 8'h5A) begin bad++; $display("FAIL bc_data ch%0d got=%h expected=5a", i, out_data[i*8 +: 8]); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bc_err got=%b expected=0", err); end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL bc_drain got=%b expected=0000", out_valid); end
`else
    out_ready = 4'b0000; in_valid = 1'b1; bcast = 1'b1; in_sel = 2'd1; in_data = 8'h5A;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nobc_ready got=%b expected=1", in_ready); end
    tick();
    in_valid = 1'b0; bcast = 1'b0;
    #1;
    total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL nobc_valid got=%b expected=0010", out_valid); end
    total++; if (out_data[15:8] !== 8'h5A) begin bad++; $display("FAIL nobc_data got=%h expected=5a", out_data[15:8]); end
    out_ready = 4'b0010;
    tick();
    out_ready = 4'b0000;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL nobc_drain got=%b expected=0000", out_valid); end
`endif
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_back_to_back();
    test_isolation_enable();
    test_invalid_sel();
    test_bcast();
    repeat (2) tick();
    for (int i = 0; i < NCH; i++) begin
      total++;
      if (sb[i].size() != 0) begin
        bad++; $display("FAIL sb_leftover ch%0d got=%0d expected=0", i, sb[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
